// File: rtl/model_share_pkg.sv
// Shared constants and types for the model_share_ctrl sequencer and its arbiter.
// Model buses are five bits wide, indexed 2..-2 (descending) or -2..2 (ascending).
package model_share_pkg;

  localparam int BUS_W  = 5;
  localparam int BUS_HI = 2;
  localparam int BUS_LO = -2;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StResp
  } state_t;

  // Index width for n requesters, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request after last_grant,
// wrapping around, so the previous winner has the lowest priority.
module rr_arbiter
  import model_share_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IdxW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] last_grant,
  output logic [NREQ-1:0] grant
);

  logic            found;
  logic [IdxW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = last_grant;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (idx == IdxW'(NREQ - 1)) ? '0 : idx + IdxW'(1);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/model_share_ctrl.sv
// Arbitrates NREQ requesters onto one shared model datapath: holds the winner's operands for
// LATENCY cycles, captures the model results and returns them over a valid/ready response.
module model_share_ctrl
  import model_share_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [BUS_W*NREQ-1:0]   req_i0,
  input  logic [BUS_W*NREQ-1:0]   req_i1,
  output logic [BUS_HI:BUS_LO]    m_i0,
  output logic [BUS_LO:BUS_HI]    m_i1,
  input  logic [BUS_HI:BUS_LO]    m_o0,
  input  logic [BUS_LO:BUS_HI]    m_o1,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [BUS_HI:BUS_LO]    rsp_o0,
  output logic [BUS_LO:BUS_HI]    rsp_o1,
  output logic                    busy
);

  localparam int unsigned     IdxW     = idx_w(NREQ);
  localparam logic [IdxW-1:0] LastInit = IdxW'(NREQ - 1);

  if (LATENCY < 1 || LATENCY > 15 || NREQ < 2 || NREQ > 8) begin : gen_param_check
    $fatal(1, "model_share_ctrl: NREQ must be 2..8 and LATENCY 1..15");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [IdxW-1:0]  last_grant_q, last_grant_d;
  logic [BUS_W-1:0] op_i0_q, op_i0_d;
  logic [BUS_W-1:0] op_i1_q, op_i1_d;
  logic [BUS_W-1:0] res_o0_q, res_o0_d;
  logic [BUS_W-1:0] res_o1_q, res_o1_d;

  logic [NREQ-1:0]  grant;
  logic [IdxW-1:0]  grant_idx;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req       (req_valid),
    .last_grant(last_grant_q),
    .grant     (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        grant_idx = IdxW'(k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    op_i0_d      = op_i0_q;
    op_i1_d      = op_i1_q;
    res_o0_d     = res_o0_q;
    res_o1_d     = res_o1_q;

    unique case (state_q)
      StIdle: begin
        // The arbiter only grants valid requesters, so any grant is a handshake.
        if (|grant) begin
          op_i0_d = req_i0[BUS_W*grant_idx +: BUS_W];
          op_i1_d = req_i1[BUS_W*grant_idx +: BUS_W];
          owner_d = grant_idx;
          cnt_d   = CNT_W'(LATENCY);
          state_d = StHold;
        end
      end
      StHold: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Packed copy keeps m_o0[2] / m_o1[-2] in the top bit, matching the output ranges.
          res_o0_d = m_o0;
          res_o1_d = m_o1;
          state_d  = StResp;
        end
      end
      StResp: begin
        if (rsp_ready[owner_q]) begin
          last_grant_d = owner_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      owner_q      <= '0;
      last_grant_q <= LastInit;
      op_i0_q      <= '0;
      op_i1_q      <= '0;
      res_o0_q     <= '0;
      res_o1_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      op_i0_q      <= op_i0_d;
      op_i1_q      <= op_i1_d;
      res_o0_q     <= res_o0_d;
      res_o1_q     <= res_o1_d;
    end
  end

  assign req_ready = (state_q == StIdle) ? grant : '0;
  assign rsp_valid = (state_q == StResp) ? (NREQ'(1) << owner_q) : '0;
  assign m_i0      = op_i0_q;
  assign m_i1      = op_i1_q;
  assign rsp_o0    = res_o0_q;
  assign rsp_o1    = res_o1_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: doc/model_share_ctrl.md
# model_share_ctrl

Sequential arbiter and sequencer sharing one `model` datapath instance (five-bit buses `i0[2:-2]`, `i1[-2:2]`, `o0[2:-2]`, `o1[-2:2]`) among `NREQ` requesters. It accepts one operation at a time and drives the operands onto the model inputs for `LATENCY` cycles. It then captures the model outputs and returns them to the requester that issued the operation through a valid/ready response. It sits directly in front of the shared `model` instance in `top`-level netlists.

## Interface
- `NREQ`, 2, number of requesters, 2..8.
- `LATENCY`, 2, cycles the model inputs are held before outputs are captured, 1..15.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NREQ: per-requester operation request.
- `req_ready` output NREQ: one-hot accept, only in IDLE.
- `req_i0` input 5*NREQ: slice k is bits [5k+4:5k]; bit 5k+4 maps to `m_i0[2]`, bit 5k to `m_i0[-2]`.
- `req_i1` input 5*NREQ: slice k; bit 5k+4 maps to `m_i1[-2]`, bit 5k to `m_i1[2]`.
- `m_i0` output [2:-2]: model operand 0.
- `m_i1` output [-2:2]: model operand 1.
- `m_o0` input [2:-2]: model result 0.
- `m_o1` input [-2:2]: model result 1.
- `rsp_valid` output NREQ: one-hot response valid to the owning requester.
- `rsp_ready` input NREQ: per-requester response accept.
- `rsp_o0` output [2:-2]: captured `m_o0`, shared by all requesters.
- `rsp_o1` output [-2:2]: captured `m_o1`, shared by all requesters.
- `busy` output 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, HOLD, RESP.
- **IDLE**
  - The round-robin arbiter selects the first valid requester after `last_grant`.
  - `req_ready` is high for that requester only.
  - On the handshake: latch its operands into registers, record `owner`, load `cnt = LATENCY`, and go to HOLD.
  - If no request is valid, stay in IDLE.
- **HOLD**
  - `m_i0`/`m_i1` are driven from the latched operands.
  - `cnt` decrements each cycle.
  - When `cnt == 1`, capture `m_o0`/`m_o1` into the `rsp_*` registers and go to RESP.
- **RESP**
  - `rsp_valid[owner]` is high.
  - `m_i0`/`m_i1` keep their latched values.
  - When `rsp_ready[owner]` is high: set `last_grant = owner` and go to IDLE.
  - `rsp_ready` of non-owners is ignored.
- **Fairness:** round-robin. `last_grant` resets to NREQ-1, so requester 0 wins the first contest. The winner becomes lowest priority after completion.
- **`req_valid` drop:** a requester dropping `req_valid` without a handshake loses nothing; no state is recorded.
- **Operand ordering:** operand registers preserve the slice-to-range mapping exactly; no reversal for the ascending `[-2:2]` ranges beyond the stated MSB mapping.
- **Reset values:** all outputs 0; state IDLE; `cnt` 0; `owner` 0; `last_grant` NREQ-1.
- **Reset mid-operation** (any state): return to IDLE next edge. The operation is dropped and `rsp_valid` is cleared with no response.
- **Out-of-range `LATENCY`:** rejected at elaboration.

## Timing
- Request accepted at edge 0. `m_i*` valid from cycle 1 through the end of RESP.
- Outputs sampled at the edge ending cycle LATENCY. `rsp_valid` is high from cycle LATENCY+1.
- Minimum issue-to-issue interval: LATENCY+2 cycles. This requires `rsp_ready` high on the first RESP cycle; the next accept happens in the IDLE cycle that follows.
- `req_ready` is a combinational function of `req_valid`, state and `last_grant`. No other outputs are combinational from inputs.
- Boundary conditions:
  - `rsp_ready` held low: stay in RESP indefinitely with `rsp_*` stable.
  - `m_o*` changing after capture: no effect on `rsp_*`.

## Structure
- Package `model_share_pkg`:
  - `BUS_W = 5`, `BUS_HI = 2`, `BUS_LO = -2`.
  - State typedef `state_t` {IDLE, HOLD, RESP}.
  - Counter width constant (4 bits).
- Sub-module `rr_arbiter`:
  - Parameter NREQ.
  - Inputs: `req`, `last_grant`.
  - Output: one-hot `grant`.
  - Purely combinational.

## Test plan
- **Single request:** reset, then requester 0 requests with `req_i0` slice = 5'b10110 and `req_i1` slice = 5'b00011, LATENCY=2.
  - Expect `m_i0[2]=1`, `m_i0[-2]=0`, `m_i1[-2]=0`, `m_i1[2]=1` from cycle 1.
  - With the model stub driving `m_o0=5'b01010`, expect `rsp_valid=2'b01` at cycle 3 and `rsp_o0=5'b01010`.
- **Contention:** both requesters valid continuously.
  - Expect grant order 0,1,0,1.
  - Expect `req_ready` one-hot, and never high outside IDLE.
- **Response backpressure:** `rsp_ready` low for 6 cycles.
  - Expect `rsp_valid` and `rsp_*` stable, `busy=1`, no new `req_ready`.
  - Release → IDLE next cycle.
- **Reset in HOLD:** assert `rst` at cycle 1 of HOLD.
  - Expect all outputs 0 and state IDLE next cycle.
  - Expect requester 0 to win again afterwards.
- **LATENCY=1 and LATENCY=15 builds:**
  - Expect `rsp_valid` at cycles 2 and 16 after the accept.
  - Expect a back-to-back issue interval of 3 and 17 cycles.
